// File: rtl/gemm_pkg.sv
// Shared constants and types for the GEMM datapath (adder tree and vector deserializer).
package gemm_pkg;

    // Default tree depth shared by the adder tree and the deserializer feeding it
    localparam int unsigned DEFAULT_LAYER      = 32'd2;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32'd32;
    localparam int unsigned DEFAULT_NUM        = 32'd1 << DEFAULT_LAYER;

    // Vector of lanes at the default geometry; lane k sits at bits [k*W +: W]
    typedef logic [DEFAULT_NUM-1:0][DEFAULT_DATA_WIDTH-1:0] lane_vec_t;

    // Number of lanes for a given tree depth
    function automatic int unsigned lane_count(input int unsigned layer);
        return 32'd1 << layer;
    endfunction

endpackage

// File: rtl/vector_deserializer.sv
// Collects a valid/ready stream of scalar words into NUM-lane vectors for the adder tree.
// A fill buffer assembles the next vector while the output register holds the current one;
// if the output register is still occupied when a vector completes, the completed vector
// waits in the fill buffer (pending) and input is stalled until the output drains.
module vector_deserializer
    import gemm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned LAYER      = DEFAULT_LAYER
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [lane_count(LAYER)-1:0][DATA_WIDTH-1:0] out_data,
    output logic [LAYER:0]                         out_count
);

    localparam int unsigned NUM = lane_count(LAYER);

    typedef logic [NUM-1:0][DATA_WIDTH-1:0] vec_t;

    localparam logic [LAYER-1:0] IDX_LAST = LAYER'(NUM - 32'd1);

    vec_t             fill_r;
    logic [LAYER-1:0] idx_r;
    logic             pending_r;
    logic [LAYER:0]   pend_count_r;
    logic             out_valid_r;
    vec_t             out_data_r;
    logic [LAYER:0]   out_count_r;

    logic             accept_s;
    logic             handshake_s;
    logic             slot_free_s;
    logic             complete_s;
    logic [LAYER:0]   count_next_s;
    vec_t             fill_next_s;

    // Handshake qualifiers; in_ready comes straight from the pending register
    always_comb begin
        accept_s     = in_valid & ~pending_r;
        handshake_s  = out_valid_r & out_ready;
        slot_free_s  = ~out_valid_r | handshake_s;
        count_next_s = {1'b0, idx_r} + {{LAYER{1'b0}}, 1'b1};
        if (accept_s) begin
            complete_s = in_last | (idx_r == IDX_LAST);
        end else begin
            complete_s = 1'b0;
        end
    end

    // Fill buffer with the incoming word merged into its lane
    always_comb begin
        fill_next_s = fill_r;
        if (accept_s) begin
            fill_next_s[idx_r] = in_data;
        end else begin
            fill_next_s = fill_r;
        end
    end

    // Fill buffer, lane index, pending flag and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_r       <= '0;
            idx_r        <= {LAYER{1'b0}};
            pending_r    <= 1'b0;
            pend_count_r <= {(LAYER+1){1'b0}};
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_count_r  <= {(LAYER+1){1'b0}};
        end else if (pending_r) begin
            // Completed vector parked in the fill buffer waits for the output to drain
            if (handshake_s) begin
                out_data_r   <= fill_r;
                out_count_r  <= pend_count_r;
                out_valid_r  <= 1'b1;
                pending_r    <= 1'b0;
                fill_r       <= '0;
                idx_r        <= {LAYER{1'b0}};
            end else begin
                pending_r    <= 1'b1;
            end
        end else if (complete_s) begin
            if (slot_free_s) begin
                // Unwritten lanes are already zero, so short vectors come out padded
                out_data_r   <= fill_next_s;
                out_count_r  <= count_next_s;
                out_valid_r  <= 1'b1;
                fill_r       <= '0;
                idx_r        <= {LAYER{1'b0}};
            end else begin
                fill_r       <= fill_next_s;
                pend_count_r <= count_next_s;
                pending_r    <= 1'b1;
                idx_r        <= {LAYER{1'b0}};
            end
        end else begin
            if (accept_s) begin
                fill_r <= fill_next_s;
                idx_r  <= idx_r + {{(LAYER-1){1'b0}}, 1'b1};
            end else begin
                fill_r <= fill_r;
            end
            // Output data is left as-is after a handshake so the bus stays quiet
            if (handshake_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    // Outputs are direct register copies
    always_comb begin
        in_ready  = ~pending_r;
        out_valid = out_valid_r;
        out_data  = out_data_r;
        out_count = out_count_r;
    end

endmodule
